// File: rtl/muldiv_seq_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer and its down-counter.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MULT_RUN = 3'd1,
    DIV_RUN  = 3'd2,
    WRITE    = 3'd3,
    DZERO    = 3'd4
  } state_e;

  typedef enum logic {
    SRC_MULT = 1'b0,
    SRC_DIV  = 1'b1
  } op_e;

  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;

  // Counter width for the longer of the two runs; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/muldiv_seq_cnt.sv
// Loadable down-counter that saturates at zero; the sequencer ends a run when it reads zero.
module muldiv_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer that runs the external mult/div units for a fixed number of cycles,
// then strobes the HI/LO load, or flags a divide by zero without running the divider.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MultReq,
  input  logic        DivReq,
  input  logic        Flush,
  input  logic [31:0] Divisor,
  output logic        MultCtrl,
  output logic        DivCtrl,
  output logic        HILOWrite,
  output logic        HISrc,
  output logic        LOSrc,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [2:0]  state_dbg
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;

  muldiv_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= SRC_MULT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Requests are only looked at in IDLE, so anything arriving while busy is dropped.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (MultReq) begin
            state_d      = MULT_RUN;
            op_d         = SRC_MULT;
            cnt_load     = 1'b1;
            cnt_load_val = MULT_LOAD;
          end else if (DivReq) begin
            if (Divisor != 32'd0) begin
              state_d      = DIV_RUN;
              op_d         = SRC_DIV;
              cnt_load     = 1'b1;
              cnt_load_val = DIV_LOAD;
            end else begin
              state_d = DZERO;
            end
          end
        end
        MULT_RUN, DIV_RUN: begin
          if (cnt_zero) state_d = WRITE;
          else          cnt_dec = 1'b1;
        end
        WRITE, DZERO: state_d = IDLE;
        default:      state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    MultCtrl  = (state_q == MULT_RUN);
    DivCtrl   = (state_q == DIV_RUN);
    HILOWrite = (state_q == WRITE);
    Done      = (state_q == WRITE);
    DivZero   = (state_q == DZERO);
    Busy      = (state_q != IDLE);
    HISrc     = op_q;
    LOSrc     = op_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: per-cycle transaction model, scenario table, corner sequences, random traffic.
module tb_muldiv_seq;

  localparam int N_MULT = 32;
  localparam int N_DIV  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MultReq = 1'b0, DivReq = 1'b0, Flush = 1'b0;
  logic [31:0] Divisor = 32'd0;
  logic        MultCtrl, DivCtrl, HILOWrite, HISrc, LOSrc, Busy, Done, DivZero;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected output word per future cycle: {MultCtrl,DivCtrl,HILOWrite,Done,DivZero,Busy,HISrc,LOSrc}
  logic [7:0] exp_q[$];
  logic       cur_op = 1'b0;

  int cyc;
  int obs_mc, obs_dc, obs_wr, obs_dz, obs_busy;
  int first_mc, last_mc, wr_cyc, last_busy;
  logic src_at_wr;

  muldiv_seq #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk(clk), .reset(reset), .MultReq(MultReq), .DivReq(DivReq), .Flush(Flush),
    .Divisor(Divisor), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl), .HILOWrite(HILOWrite),
    .HISrc(HISrc), .LOSrc(LOSrc), .Busy(Busy), .Done(Done), .DivZero(DivZero),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] word(input logic mc, input logic dc, input logic wr,
                                      input logic dz, input logic busy, input logic src);
    return {mc, dc, wr, wr, dz, busy, src, src};
  endfunction

  function automatic logic [7:0] outs();
    return {MultCtrl, DivCtrl, HILOWrite, Done, DivZero, Busy, HISrc, LOSrc};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; obs_mc = 0; obs_dc = 0; obs_wr = 0; obs_dz = 0; obs_busy = 0;
    first_mc = -1; last_mc = -1; wr_cyc = -1; last_busy = -1; src_at_wr = 1'bx;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic mreq, input logic dreq, input logic fl, input logic [31:0] dv);
    logic [7:0] e, a;
    bit idle_now;
    MultReq = mreq; DivReq = dreq; Flush = fl; Divisor = dv;
    @(negedge clk);
    idle_now = (exp_q.size() == 0);
    e = idle_now ? word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_op) : exp_q[0];
    a = outs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle_outputs: got %b expected %b (t=%0t)", a, e, $time);
    end
    if (MultCtrl) begin
      obs_mc++;
      if (first_mc < 0) first_mc = cyc;
      last_mc = cyc;
    end
    if (DivCtrl) obs_dc++;
    if (HILOWrite) begin obs_wr++; wr_cyc = cyc; src_at_wr = HISrc; end
    if (DivZero) obs_dz++;
    if (Busy) begin obs_busy++; last_busy = cyc; end
    cyc++;
    if (!idle_now) void'(exp_q.pop_front());
    if (fl) begin
      exp_q.delete();
    end else if (idle_now && mreq) begin
      cur_op = 1'b0;
      repeat (N_MULT) exp_q.push_back(word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(word(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    end else if (idle_now && dreq) begin
      if (dv != 32'd0) begin
        cur_op = 1'b1;
        repeat (N_DIV) exp_q.push_back(word(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(word(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
      end else begin
        exp_q.push_back(word(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, cur_op));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic mid_reset();
    reset = 1'b1;
    #2;
    check("async_reset_outputs", int'(outs()), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    cur_op = 1'b0;
  endtask

  typedef struct {
    logic        mreq;
    logic        dreq;
    logic [31:0] dv;
    int          exp_mc;
    int          exp_dc;
    int          exp_wr;
    int          exp_dz;
    int          exp_busy;
    logic        exp_src;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd0,          32, 0,  1, 0, 33, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'd7,          0,  32, 1, 0, 33, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'd0,          0,  0,  0, 1, 1,  1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'd9,          32, 0,  1, 0, 33, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  0,  32, 1, 0, 33, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'd0,          32, 0,  1, 0, 33, 1'b0};

    @(negedge clk);
    check("reset_outputs", int'(outs()), 0);
    check("reset_state", int'(state_dbg), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Scenario table
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      step(vecs[v].mreq, vecs[v].dreq, 1'b0, vecs[v].dv);
      idle_steps(40);
      check("tbl_mult_cycles", obs_mc, vecs[v].exp_mc);
      check("tbl_div_cycles", obs_dc, vecs[v].exp_dc);
      check("tbl_writes", obs_wr, vecs[v].exp_wr);
      check("tbl_divzero", obs_dz, vecs[v].exp_dz);
      check("tbl_busy_cycles", obs_busy, vecs[v].exp_busy);
      check("tbl_src", int'(HISrc), int'(vecs[v].exp_src));
    end

    // Multiply requested at cycle 5: enable 6..37, write 38, idle from 39
    clear_obs();
    idle_steps(5);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    idle_steps(40);
    check("mult_first_enable", first_mc, 6);
    check("mult_last_enable", last_mc, 37);
    check("mult_write_cycle", wr_cyc, 38);
    check("mult_last_busy", last_busy, 38);
    check("mult_write_src", int'(src_at_wr), 0);

    // Both requests, then a divide request mid-run that must be ignored
    clear_obs();
    step(1'b1, 1'b1, 1'b0, 32'd5);
    idle_steps(9);
    step(1'b0, 1'b1, 1'b0, 32'd3);
    idle_steps(30);
    check("ignore_div_dc", obs_dc, 0);
    check("ignore_div_writes", obs_wr, 1);

    // Flush at run cycle 15, then a clean multiply
    clear_obs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    idle_steps(14);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    idle_steps(5);
    check("flush_no_write", obs_wr, 0);
    check("flush_run_cycles", obs_mc, 15);
    clear_obs();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    idle_steps(35);
    check("post_flush_writes", obs_wr, 1);

    // Flush beats a request in the same idle cycle
    clear_obs();
    step(1'b1, 1'b0, 1'b1, 32'd0);
    idle_steps(3);
    check("flush_vs_req_busy", obs_busy, 0);

    // Reset at run cycle 15, then a clean divide
    clear_obs();
    step(1'b0, 1'b1, 1'b0, 32'd11);
    idle_steps(14);
    mid_reset();
    idle_steps(5);
    check("reset_no_write", obs_wr, 0);
    check("reset_src_mult", int'(HISrc), 0);
    clear_obs();
    step(1'b0, 1'b1, 1'b0, 32'd11);
    idle_steps(35);
    check("post_reset_writes", obs_wr, 1);
    check("post_reset_div_cycles", obs_dc, 32);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic mr, dr, fl;
      logic [31:0] dv;
      mr = ($urandom_range(0, 9) == 0);
      dr = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 59) == 0);
      dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(mr, dr, fl, dv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
